// File: rtl/x25519_pkg.sv
// Shared constants and state encoding for the X25519 u-coordinate encoder
// and any other stage that works on field elements modulo 2^255-19.
package x25519_pkg;

   // Field prime p = 2^255 - 19, expressed as all-ones minus 18.
   localparam logic [254:0] P25519 = {255{1'b1}} - 255'd18;

   // Number of bytes in an encoded field element.
   localparam int ENC_BYTES = 32;

   // Encoder sequencing states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READY  = 2'd1,
      S_REDUCE = 2'd2,
      S_SEND   = 2'd3
   } state_e;

endpackage

// File: rtl/x25519_encode_modp_reduce.sv
// Combinational canonical reduction of a 255-bit value modulo p = 2^255-19.
// Any 255-bit input is below 2p, so a single conditional subtraction is
// enough to land in 0..p-1.
module modp_reduce
   import x25519_pkg::*;
(
   input  logic [254:0] x,
   output logic [254:0] y
);

   // Subtract p once when the input is at or above p.
   always_comb begin
      y = x;
      if (x >= P25519) begin
         y = x - P25519;
      end
   end

endmodule

// File: rtl/x25519_encode.sv
// X25519 field-element encoder: accepts a possibly non-canonical 255-bit
// value, reduces it modulo 2^255-19 and streams the 32-byte little-endian
// encoding (or big-endian with LSB_FIRST=0) over a valid/ready byte port.
// Optional feature macro: ENCODE_ZERO_CHECK_EN enables the is_zero flag;
// without it is_zero is tied low and no zero-detect logic exists.
module x25519_encode
   import x25519_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic [254:0] X,
   input  logic         req_valid,
   output logic         req_ready,
   output logic         req_busy,
   output logic [7:0]   out_byte,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         is_zero
);

   localparam logic [4:0] LAST_COUNT = 5'(ENC_BYTES - 1);

   state_e       state;
   logic [254:0] value;
   logic [254:0] reduced;
   logic [4:0]   count;
   logic [4:0]   byte_idx;
   logic [255:0] enc;
   logic         accept;
   logic         transfer;

   modp_reduce u_reduce (
      .x (value),
      .y (reduced)
   );

   // Bit 255 of the encoding is always zero; byte order follows LSB_FIRST.
   always_comb begin
      accept   = (state == S_IDLE) && req_valid;
      transfer = (state == S_SEND) && out_valid && out_ready;
      enc      = {1'b0, value};
      byte_idx = LSB_FIRST ? count : (LAST_COUNT - count);
      out_byte = 8'h00;
      if (out_valid) begin
         out_byte = enc[{byte_idx, 3'b000} +: 8];
      end
      out_last = out_valid && (count == LAST_COUNT);
   end

   // Request handshake, reduction step and byte sequencing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         value     <= '0;
         count     <= '0;
         req_ready <= 1'b0;
         req_busy  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  value     <= X;
                  req_ready <= 1'b1;
                  req_busy  <= 1'b1;
                  state     <= S_READY;
               end
            end
            S_READY: begin
               req_ready <= 1'b0;
               state     <= S_REDUCE;
            end
            S_REDUCE: begin
               value     <= reduced;
               out_valid <= 1'b1;
               count     <= '0;
               state     <= S_SEND;
            end
            S_SEND: begin
               if (transfer) begin
                  if (count == LAST_COUNT) begin
                     out_valid <= 1'b0;
                     req_busy  <= 1'b0;
                     count     <= '0;
                     state     <= S_IDLE;
                  end else begin
                     count <= count + 5'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ENCODE_ZERO_CHECK_EN
   logic zero_q;

   // Zero flag is captured from the canonical value and held until the next request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         zero_q <= 1'b0;
      end else if (accept) begin
         zero_q <= 1'b0;
      end else if (state == S_REDUCE) begin
         zero_q <= (reduced == '0);
      end
   end

   assign is_zero = zero_q;
`else
   assign is_zero = 1'b0;
`endif

endmodule

// File: tb/tb_x25519_encode.sv
// Directed self-checking bench for x25519_encode: canonical reduction cases,
// back-pressure, mid-stream reset and big-endian ordering.
module tb_x25519_encode;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [254:0] x_in = '0;
   logic         req_valid_a = 1'b0;
   logic         req_valid_b = 1'b0;
   logic         out_ready = 1'b0;

   logic         req_ready_a, req_busy_a, out_valid_a, out_last_a, is_zero_a;
   logic [7:0]   out_byte_a;
   logic         req_ready_b, req_busy_b, out_valid_b, out_last_b, is_zero_b;
   logic [7:0]   out_byte_b;

   logic         mon_ready, mon_busy, mon_valid, mon_last, mon_zero;
   logic [7:0]   mon_byte;
   bit           sel = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [254:0] P = {255{1'b1}} - 255'd18;
`ifdef ENCODE_ZERO_CHECK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif

   x25519_encode #(.LSB_FIRST(1'b1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .X         (x_in),
      .req_valid (req_valid_a),
      .req_ready (req_ready_a),
      .req_busy  (req_busy_a),
      .out_byte  (out_byte_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_last  (out_last_a),
      .is_zero   (is_zero_a)
   );

   x25519_encode #(.LSB_FIRST(1'b0)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .X         (x_in),
      .req_valid (req_valid_b),
      .req_ready (req_ready_b),
      .req_busy  (req_busy_b),
      .out_byte  (out_byte_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_last  (out_last_b),
      .is_zero   (is_zero_b)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Route the selected instance's outputs to a common monitor view.
   always_comb begin
      mon_ready = sel ? req_ready_b : req_ready_a;
      mon_busy  = sel ? req_busy_b  : req_busy_a;
      mon_valid = sel ? out_valid_b : out_valid_a;
      mon_last  = sel ? out_last_b  : out_last_a;
      mon_zero  = sel ? is_zero_b   : is_zero_a;
      mon_byte  = sel ? out_byte_b  : out_byte_a;
   end

   task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // Issue one request from a falling edge and check the handshake and latency.
   task automatic apply_stimulus(input bit which, input logic [254:0] x, input bit exp_zero);
      sel  = which;
      x_in = x;
      if (which) req_valid_b = 1'b1;
      else       req_valid_a = 1'b1;
      @(negedge clk);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      check_output("req_ready_pulse", 256'(mon_ready), 256'd1);
      check_output("req_busy_on", 256'(mon_busy), 256'd1);
      @(negedge clk);
      check_output("req_ready_drop", 256'(mon_ready), 256'd0);
      check_output("no_early_valid", 256'(mon_valid), 256'd0);
      @(negedge clk);
      check_output("first_valid_latency", 256'(mon_valid), 256'd1);
      check_output("is_zero_at_start", 256'(mon_zero), 256'(exp_zero));
   endtask

   // Collect up to 'limit' transfers; optionally stall at one byte or poke req_valid_b.
   task automatic receive_stream(input int limit, input int stall_at, input int poke_at,
                                 output logic [255:0] got, output int n,
                                 output int last_idx, output int lasts);
      int         stalls = 0;
      logic [7:0] held = '0;
      got      = '0;
      n        = 0;
      last_idx = -1;
      lasts    = 0;
      for (int cyc = 0; cyc < 200 && n < limit; cyc++) begin
         if (n == stall_at && stalls < 5 && mon_valid) begin
            out_ready = 1'b0;
            if (stalls == 0) begin
               held = mon_byte;
            end else begin
               check_output("stall_byte_stable", 256'(mon_byte), 256'(held));
               check_output("stall_valid_held", 256'(mon_valid), 256'd1);
            end
            stalls++;
         end else begin
            out_ready = 1'b1;
            if (mon_valid) begin
               got[8*n +: 8] = mon_byte;
               if (mon_last) begin
                  lasts++;
                  last_idx = n;
               end
               n++;
            end
         end
         if (n == poke_at) begin
            x_in        = 255'd5;
            req_valid_b = 1'b1;
         end else begin
            req_valid_b = 1'b0;
         end
         @(negedge clk);
      end
      req_valid_b = 1'b0;
   endtask

   // Check the handshake outputs once a full stream has drained.
   task automatic check_drained(input bit exp_zero);
      check_output("busy_after_last", 256'(mon_busy), 256'd0);
      check_output("valid_after_last", 256'(mon_valid), 256'd0);
      check_output("last_after_last", 256'(mon_last), 256'd0);
      check_output("is_zero_held", 256'(mon_zero), 256'(exp_zero));
   endtask

   // Time limit so the bench always ends.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      logic [255:0] got;
      int           n, last_idx, lasts;
      bit           seen;

      #2 rst = 1'b0;
      #1;
      check_output("reset_req_ready", 256'(req_ready_a), 256'd0);
      check_output("reset_req_busy", 256'(req_busy_a), 256'd0);
      check_output("reset_out_valid", 256'(out_valid_a), 256'd0);
      check_output("reset_out_last", 256'(out_last_a), 256'd0);
      check_output("reset_out_byte", 256'(out_byte_a), 256'd0);
      check_output("reset_is_zero", 256'(is_zero_a), 256'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] X=9 little-endian stream");
      apply_stimulus(1'b0, 255'd9, 1'b0);
      receive_stream(32, -1, -1, got, n, last_idx, lasts);
      check_output("x9_count", 256'(n), 256'd32);
      check_output("x9_bytes", got, 256'h09);
      check_output("x9_last_index", 256'(last_idx), 256'd31);
      check_output("x9_last_once", 256'(lasts), 256'd1);
      check_drained(1'b0);

      $display("[TB] X=p reduces to zero");
      apply_stimulus(1'b0, P, ZC);
      receive_stream(32, -1, -1, got, n, last_idx, lasts);
      check_output("p_count", 256'(n), 256'd32);
      check_output("p_bytes", got, 256'h0);
      check_drained(ZC);

      $display("[TB] X=2^255-1 reduces to 18");
      apply_stimulus(1'b0, {255{1'b1}}, 1'b0);
      receive_stream(32, -1, -1, got, n, last_idx, lasts);
      check_output("max_count", 256'(n), 256'd32);
      check_output("max_bytes", got, 256'h12);

      $display("[TB] X=p-1 is already canonical");
      apply_stimulus(1'b0, P - 255'd1, 1'b0);
      receive_stream(32, -1, -1, got, n, last_idx, lasts);
      check_output("pm1_count", 256'(n), 256'd32);
      check_output("pm1_bytes", got, {8'h7F, {30{8'hFF}}, 8'hEC});

      $display("[TB] back-pressure at byte 10");
      apply_stimulus(1'b0, 255'd9, 1'b0);
      receive_stream(32, 10, -1, got, n, last_idx, lasts);
      check_output("stall_count", 256'(n), 256'd32);
      check_output("stall_bytes", got, 256'h09);
      check_output("stall_last_index", 256'(last_idx), 256'd31);
      check_drained(1'b0);

      $display("[TB] reset mid-stream at byte 15");
      apply_stimulus(1'b0, 255'd9, 1'b0);
      receive_stream(15, -1, -1, got, n, last_idx, lasts);
      check_output("pre_reset_count", 256'(n), 256'd15);
      rst = 1'b0;
      #1;
      check_output("midrst_out_valid", 256'(out_valid_a), 256'd0);
      check_output("midrst_out_byte", 256'(out_byte_a), 256'd0);
      check_output("midrst_out_last", 256'(out_last_a), 256'd0);
      check_output("midrst_req_busy", 256'(req_busy_a), 256'd0);
      check_output("midrst_req_ready", 256'(req_ready_a), 256'd0);
      check_output("midrst_is_zero", 256'(is_zero_a), 256'd0);
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | out_valid_a;
      end
      check_output("no_bytes_after_reset", 256'(seen), 256'd0);
      apply_stimulus(1'b0, 255'd1, 1'b0);
      receive_stream(32, -1, -1, got, n, last_idx, lasts);
      check_output("x1_count", 256'(n), 256'd32);
      check_output("x1_bytes", got, 256'h01);
      check_output("x1_last_index", 256'(last_idx), 256'd31);

      $display("[TB] big-endian instance with a stray request mid-stream");
      apply_stimulus(1'b1, 255'd9, 1'b0);
      receive_stream(32, -1, 5, got, n, last_idx, lasts);
      check_output("msb_count", 256'(n), 256'd32);
      check_output("msb_bytes", got, {8'h09, 248'h0});
      check_output("msb_last_index", 256'(last_idx), 256'd31);
      check_output("msb_last_once", 256'(lasts), 256'd1);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | out_valid_b | req_busy_b;
      end
      check_output("msb_no_restart", 256'(seen), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
